// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin mux arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned HCNT_W  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward,
// optionally skipping one index (used to preempt the current holder).
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               excl_en,
    input  logic [IDX_W-1:0]   excl_idx,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            // IDX_W-bit addition wraps index 3 back to 0
            w_cand = ptr + IDX_W'(k);
            if (!found && req[w_cand] && !(excl_en && (w_cand == excl_idx))) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with hold limit, driving a shared 4:1 data mux.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [WIDTH-1:0]     I0,
    input  logic [WIDTH-1:0]     I1,
    input  logic [WIDTH-1:0]     I2,
    input  logic [WIDTH-1:0]     I3,
    output logic [NUM_REQ-1:0]   GNT,
    output logic [IDX_W-1:0]     SEL,
    output logic [WIDTH-1:0]     Y,
    output logic                 VALID
);

    localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(MAX_HOLD);

    state_e              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [IDX_W-1:0]    r_sel;
    logic                r_valid;
    logic [IDX_W-1:0]    r_ptr;
    logic [HCNT_W-1:0]   r_hcnt;

    logic                w_excl_en;
    logic                w_found;
    logic [IDX_W-1:0]    w_idx;
    logic                w_cur_req;

    // While granting, exclusion of the holder makes w_found mean "someone else waits";
    // on release the holder's REQ is already low, so the exclusion is harmless there.
    assign w_excl_en = (r_state == GRANT);
    assign w_cur_req = REQ[r_sel];

    rr_pick u_pick (
        .req      (REQ),
        .ptr      (r_ptr),
        .excl_en  (w_excl_en),
        .excl_idx (r_sel),
        .found    (w_found),
        .idx      (w_idx)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_hcnt  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_gnt   <= onehot(w_idx);
                        r_sel   <= w_idx;
                        r_valid <= 1'b1;
                        r_hcnt  <= HCNT_W'(1);
                        r_ptr   <= w_idx + IDX_W'(1);
                    end
                end
                GRANT: begin
                    if ((!w_cur_req && w_found) ||
                        (w_cur_req && (r_hcnt >= HOLD_LIM) && w_found)) begin
                        r_gnt  <= onehot(w_idx);
                        r_sel  <= w_idx;
                        r_hcnt <= HCNT_W'(1);
                        r_ptr  <= w_idx + IDX_W'(1);
                    end else if (!w_cur_req) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_hcnt  <= '0;
                    end else if (r_hcnt < HOLD_LIM) begin
                        r_hcnt <= r_hcnt + HCNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Y = '0;
        if (r_valid) begin
            unique case (r_sel)
                2'd0:    Y = I0;
                2'd1:    Y = I1;
                2'd2:    Y = I2;
                default: Y = I3;
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign SEL   = r_sel;
    assign VALID = r_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_rr_mux_arbiter;

    localparam int unsigned W = 8;

    logic         CLK;
    logic         RST_N;
    logic [3:0]   REQ;
    logic [W-1:0] I0, I1, I2, I3;

    logic [3:0]   gnt4, gnt1;
    logic [1:0]   sel4, sel1;
    logic [W-1:0] y4, y1;
    logic         valid4, valid1;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .I0    (I0),
        .I1    (I1),
        .I2    (I2),
        .I3    (I3),
        .GNT   (gnt4),
        .SEL   (sel4),
        .Y     (y4),
        .VALID (valid4)
    );

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .I0    (I0),
        .I1    (I1),
        .I2    (I2),
        .I3    (I3),
        .GNT   (gnt1),
        .SEL   (sel1),
        .Y     (y1),
        .VALID (valid1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        REQ   = 4'b0000;
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
    endtask

    function automatic logic [W-1:0] data_of(input logic [1:0] s);
        case (s)
            2'd0:    return 8'hA1;
            2'd1:    return 8'hB2;
            2'd2:    return 8'hC3;
            default: return 8'hD4;
        endcase
    endfunction

    initial begin
        logic [3:0] e_g;
        logic [1:0] e_s;

        RST_N = 1'b0;
        REQ   = 4'b0000;
        I0 = 8'hA1; I1 = 8'hB2; I2 = 8'hC3; I3 = 8'hD4;

        // Reset state
        step();
        step();
        chk("rst_gnt", 32'(gnt4), 32'h0);
        chk("rst_sel", 32'(sel4), 32'h0);
        chk("rst_valid", 32'(valid4), 32'h0);
        chk("rst_y", 32'(y4), 32'h0);
        RST_N = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_gnt", 32'(gnt4), 32'h0);
            chk("idle_valid", 32'(valid4), 32'h0);
            chk("idle_sel", 32'(sel4), 32'h0);
            chk("idle_y", 32'(y4), 32'h0);
        end

        // Single request from requester 2
        REQ = 4'b0100;
        step();
        chk("single_gnt", 32'(gnt4), 32'h4);
        chk("single_sel", 32'(sel4), 32'h2);
        chk("single_valid", 32'(valid4), 32'h1);
        chk("single_y", 32'(y4), 32'hC3);
        I2 = 8'h5A;
        #1;
        chk("single_y_comb", 32'(y4), 32'h5A);
        I2 = 8'hC3;
        REQ = 4'b0000;
        step();
        chk("drop_gnt", 32'(gnt4), 32'h0);
        chk("drop_valid", 32'(valid4), 32'h0);
        chk("drop_sel", 32'(sel4), 32'h2);
        chk("drop_y", 32'(y4), 32'h0);

        // All requesting: MAX_HOLD=1 rotates each cycle, MAX_HOLD=4 holds 4 cycles
        pulse_reset();
        REQ = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            e_g = 4'b0001;
            e_g = e_g << (i % 4);
            e_s = 2'(i % 4);
            chk("rot_gnt1", 32'(gnt1), 32'(e_g));
            chk("rot_sel1", 32'(sel1), 32'(e_s));
            chk("rot_y1", 32'(y1), 32'(data_of(e_s)));
            chk("rot_gnt4", 32'(gnt4), (i < 4) ? 32'h1 : 32'h2);
        end

        // Hold limit alternates two requesters every 4 cycles
        pulse_reset();
        REQ = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("hold_gnt4", 32'(gnt4), (((i / 4) % 2) == 0) ? 32'h1 : 32'h2);
            chk("hold_valid4", 32'(valid4), 32'h1);
        end

        // Sole requester keeps the grant indefinitely
        REQ = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("solo_gnt4", 32'(gnt4), 32'h1);
            chk("solo_gnt1", 32'(gnt1), 32'h1);
        end

        // Release with a waiter: 3 -> 0 with no VALID gap, PTR wraps
        pulse_reset();
        REQ = 4'b1000;
        step();
        chk("rel_gnt_a", 32'(gnt4), 32'h8);
        REQ = 4'b1001;
        step();
        chk("rel_gnt_b", 32'(gnt4), 32'h8);
        REQ = 4'b0001;
        step();
        chk("rel_gnt_c", 32'(gnt4), 32'h1);
        chk("rel_valid_c", 32'(valid4), 32'h1);
        chk("rel_sel_c", 32'(sel4), 32'h0);
        chk("rel_y_c", 32'(y4), 32'hA1);

        // Release with waiter behind PTR, regrant from PTR scan (PTR=1, wait on 2 and 0)
        REQ = 4'b0101;
        step();
        REQ = 4'b0100;
        step();
        chk("rel2_gnt", 32'(gnt4), 32'h4);
        chk("rel2_sel", 32'(sel4), 32'h2);

        // Asynchronous reset in the middle of a grant
        pulse_reset();
        REQ = 4'b0010;
        step();
        chk("ar_pre_gnt", 32'(gnt4), 32'h2);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt4), 32'h0);
        chk("ar_valid", 32'(valid4), 32'h0);
        chk("ar_y", 32'(y4), 32'h0);
        chk("ar_sel", 32'(sel4), 32'h0);
        step();
        RST_N = 1'b1;
        REQ = 4'b1010;
        step();
        chk("ar_post_gnt", 32'(gnt4), 32'h2);
        chk("ar_post_sel", 32'(sel4), 32'h1);
        chk("ar_post_y", 32'(y4), 32'hB2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data multiplexer among four requesters.
- Each requester raises REQ and presents data. The arbiter issues a one-hot grant, drives the 2-bit select, and forwards the granted requester's data to Y with a VALID qualifier.
- A hold limit stops any requester from monopolising the shared output while others are waiting.

Parameters:
- WIDTH, 1: data width of I0..I3 and Y.
- MAX_HOLD, 4: maximum consecutive grant cycles while another requester is pending. Legal range 1..15; 1 gives per-cycle rotation.

Ports:
- CLK  input  1  single clock, rising-edge.
- RST_N  input  1  reset, asynchronous and active-low; all state cleared while low.
- REQ  input  4  request per requester; bit k belongs to requester k.
- I0  input  WIDTH  data of requester 0.
- I1  input  WIDTH  data of requester 1.
- I2  input  WIDTH  data of requester 2.
- I3  input  WIDTH  data of requester 3.
- GNT  output  4  one-hot grant, registered.
- SEL  output  2  index of current or last grant, registered; {S1,S0} order.
- Y  output  WIDTH  forwarded data: I[SEL] when VALID=1, otherwise 0 (combinational from registered SEL/VALID).
- VALID  output  1  high while a grant is active, registered.

Behaviour:
- Reset (RST_N low, takes effect immediately): GNT=0000, SEL=00, VALID=0, Y=0, state=IDLE, PTR=0, HCNT=0.
- Internal state:
  - PTR (2 bits): highest-priority index for the next arbitration.
  - HCNT (4 bits): cycles the current grant has been held.
- Pick rule: scan REQ starting at PTR in order PTR, PTR+1, ... mod 4. The first asserted bit wins. Index 3 wraps to 0.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise, at the next edge: GNT=onehot(win), SEL=win, VALID=1, HCNT=1, PTR=win+1 mod 4, go to GRANT.
  - REQ-to-GNT latency is 1 cycle.
- GRANT, evaluated each edge, first matching rule applies:
  1. REQ[SEL]==0 (release) and another REQ set: regrant directly to the pick from PTR. There is no idle bubble. HCNT=1, PTR=new+1.
  2. REQ[SEL]==0 and no other REQ: go to IDLE. GNT=0000, VALID=0; SEL holds its last value; HCNT=0.
  3. REQ[SEL]==1, HCNT>=MAX_HOLD, and another REQ set (preempt): grant the pick from PTR, excluding the current index. HCNT=1, PTR=new+1.
  4. Otherwise keep the grant. HCNT increments and saturates at MAX_HOLD.
- Requester handshake:
  - Keep REQ high until GNT is seen, then drop REQ to release.
  - A preempted requester that keeps REQ high re-enters arbitration normally.
- Invariants:
  - GNT is one-hot or zero.
  - VALID == |GNT.
  - GNT == onehot(SEL) whenever VALID=1.
- Data path: Y follows I[SEL] combinationally within the cycle while VALID=1; input changes propagate without a register.
- Reset during GRANT: outputs drop asynchronously. After release the arbiter restarts from PTR=0.
- REQ changes between edges have no effect until the next edge.

Decomposition:
- Package rr_arb_pkg:
  - Constants NUM_REQ=4, IDX_W=2, HCNT_W=4.
  - State enum {IDLE, GRANT}.
- Sub-module rr_pick, combinational:
  - Inputs: req[3:0], ptr[1:0], excl_en, excl_idx[1:0].
  - Outputs: found, idx[1:0].
  - Used once for rules 1 and 3 and for IDLE arbitration.
- Top contains: FSM, PTR/HCNT registers, 4:1 data mux indexed by SEL.

Test Plan:
- Reset/idle: RST_N=0 then 1, REQ=0000 for 5 cycles -> GNT=0000, SEL=00, VALID=0, Y=0 throughout.
- Single request: REQ=0100, I2=1, others 0 -> one edge later GNT=0100, SEL=10, VALID=1, Y=1. Drop REQ -> next edge GNT=0000, VALID=0, SEL stays 10.
- Rotation: REQ=1111 held, MAX_HOLD=1 -> GNT sequence 0001, 0010, 0100, 1000, 0001, ...; SEL follows 00, 01, 10, 11, 00.
- Hold limit: REQ=0011 held, MAX_HOLD=4 -> GNT=0001 for 4 cycles, then 0010 for 4 cycles, repeating. With REQ=0001 only, GNT stays 0001 indefinitely (HCNT saturates).
- Release with waiters: GNT=1000, then REQ changes 1001 -> 0001 on the same edge -> next edge GNT=0001 with no VALID gap (PTR wrapped 3 -> 0).
- Async reset mid-grant: GNT=0010, RST_N pulled low mid-cycle -> GNT=0000, VALID=0 before the next edge. After release with REQ=1010 -> GNT=0010 (PTR=0 scan).
